// File: rtl/ysyx_24080006_mdu_ctrl.sv
// Iterative RV32M multiply/divide sequencer that borrows the EX-stage ALU adder
// through the mdu_enable / mdu2alu / alu2mdu side port instead of owning an adder.
module ysyx_24080006_mdu_ctrl #(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        mdu_enable,
    output logic [65:0] mdu2alu,
    input  logic [66:0] alu2mdu
);

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_ITER,
        S_FIX_LO,
        S_FIX_HI,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_mdu_en;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;

    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [4:0]          r_cnt;
    logic                r_a_neg;
    logic                r_b_neg;
    logic                r_carry;
    logic                r_special;
    logic [DATA_W-1:0]   r_spec_val;

    logic [33:0]         w_res34;
    logic [DATA_W-1:0]   w_res32;
    logic                w_unused_alu;
    logic [DATA_W:0]     w_add_a;
    logic [DATA_W:0]     w_add_b;
    logic                w_accept;
    logic                w_sa;
    logic                w_sb;
    logic                w_divz;
    logic                w_ovf;
    logic                w_special;
    logic [DATA_W-1:0]   w_spec_val;
    logic                w_is_div;
    logic [DATA_W:0]     w_rsh;
    logic                w_q;
    logic [DATA_W:0]     w_sum_mul;
    logic [DATA_W-1:0]   w_abs_b;
    logic                w_neg_lo;
    logic                w_neg_hi;
    logic                w_sel_hi;
    logic [DATA_W-1:0]   w_hi_fixed;
    logic [DATA_W-1:0]   w_result;

    // x/0 yields all-ones quotient and the dividend as remainder; INT_MIN/-1 wraps.
    function automatic logic [DATA_W-1:0] special_result(
        input logic              divz,
        input logic              is_rem,
        input logic [DATA_W-1:0] a
    );
        if (divz)
            special_result = is_rem ? a : {DATA_W{1'b1}};
        else
            special_result = is_rem ? {DATA_W{1'b0}} : {1'b1, {(DATA_W-1){1'b0}}};
    endfunction

    assign w_res34      = alu2mdu[66:33];
    assign w_res32      = alu2mdu[32:1];
    assign w_unused_alu = alu2mdu[0] ^ w_res34[0];

    assign in_ready   = reset_n && (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign mdu_enable = r_mdu_en;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign mdu2alu    = r_mdu_en ? {w_add_a, w_add_b} : 66'd0;

    assign w_accept   = in_valid && in_ready && !flush;
    assign w_sa       = (mdu_op == 3'b001) || (mdu_op == 3'b010) ||
                        (mdu_op == 3'b100) || (mdu_op == 3'b110);
    assign w_sb       = (mdu_op == 3'b001) || (mdu_op == 3'b100) || (mdu_op == 3'b110);
    assign w_divz     = mdu_op[2] && (op_b == '0);
    assign w_ovf      = mdu_op[2] && !mdu_op[0] && (op_a == 32'h8000_0000) &&
                        (op_b == 32'hFFFF_FFFF);
    assign w_special  = w_divz || w_ovf;
    assign w_spec_val = special_result(w_divz, mdu_op[1], op_a);

    assign w_is_div   = r_op[2];
    assign w_rsh      = {r_hi, r_lo[DATA_W-1]};
    assign w_q        = w_rsh[DATA_W] | w_res34[33];
    assign w_sum_mul  = r_lo[0] ? w_res34[33:1] : {1'b0, r_hi};
    assign w_abs_b    = r_b_neg ? w_res32 : r_b;
    assign w_neg_lo   = r_a_neg ^ r_b_neg;
    assign w_neg_hi   = w_is_div ? r_a_neg : (r_a_neg ^ r_b_neg);
    assign w_sel_hi   = w_is_div ? r_op[1] : (r_op[1:0] != 2'b00);
    assign w_hi_fixed = w_neg_hi ? w_res32 : r_hi;
    assign w_result   = w_sel_hi ? w_hi_fixed : r_lo;

    // Adder operands; the LSB pair acts as carry-in (1+1 carries into bit 1).
    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        case (r_state)
            S_ABS_A: begin
                w_add_a = {{DATA_W{1'b0}}, 1'b1};
                w_add_b = {~r_a, 1'b1};
            end
            S_ABS_B: begin
                w_add_a = {{DATA_W{1'b0}}, 1'b1};
                w_add_b = {~r_b, 1'b1};
            end
            S_ITER: begin
                if (w_is_div) begin
                    w_add_a = {w_rsh[DATA_W-1:0], 1'b1};
                    w_add_b = {~r_b, 1'b1};
                end else if (r_lo[0]) begin
                    w_add_a = {r_hi, 1'b0};
                    w_add_b = {r_a, 1'b0};
                end
            end
            S_FIX_LO: begin
                w_add_a = {~r_lo, 1'b1};
                w_add_b = {{DATA_W{1'b0}}, 1'b1};
            end
            S_FIX_HI: begin
                w_add_a = {~r_hi, 1'b1};
                w_add_b = {{DATA_W{1'b0}}, w_is_div ? 1'b1 : r_carry};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_mdu_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (flush && (r_state != S_IDLE)) begin
            r_state     <= S_IDLE;
            r_mdu_en    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (FAST_SPECIAL && w_special) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_spec_val;
                        end else begin
                            r_state  <= S_ABS_A;
                            r_mdu_en <= 1'b1;
                        end
                    end
                end
                S_ABS_A:  r_state <= S_ABS_B;
                S_ABS_B:  r_state <= S_ITER;
                S_ITER: begin
                    if (r_cnt == 5'd0)
                        r_state <= S_FIX_LO;
                end
                S_FIX_LO: r_state <= S_FIX_HI;
                S_FIX_HI: begin
                    r_state     <= S_DONE;
                    r_mdu_en    <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_special ? r_spec_val : w_result;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mdu_en    <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: hi/lo hold the 64-bit product, or remainder/quotient when dividing.
    always_ff @(posedge clock) begin
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    r_op       <= mdu_op;
                    r_a        <= op_a;
                    r_b        <= op_b;
                    r_a_neg    <= w_sa & op_a[DATA_W-1];
                    r_b_neg    <= w_sb & op_b[DATA_W-1];
                    r_special  <= w_special;
                    r_spec_val <= w_spec_val;
                end
            end
            S_ABS_A: begin
                if (r_a_neg)
                    r_a <= w_res32;
            end
            S_ABS_B: begin
                r_b   <= w_abs_b;
                r_hi  <= '0;
                r_lo  <= w_is_div ? r_a : w_abs_b;
                r_cnt <= 5'd31;
            end
            S_ITER: begin
                r_cnt <= r_cnt - 5'd1;
                if (w_is_div) begin
                    r_hi <= w_q ? w_res32 : w_rsh[DATA_W-1:0];
                    r_lo <= {r_lo[DATA_W-2:0], w_q};
                end else begin
                    r_hi <= w_sum_mul[DATA_W:1];
                    r_lo <= {w_sum_mul[0], r_lo[DATA_W-1:1]};
                end
            end
            S_FIX_LO: begin
                r_carry <= w_res34[33];
                if (w_neg_lo)
                    r_lo <= w_res32;
            end
            S_FIX_HI: begin
                if (w_neg_hi)
                    r_hi <= w_res32;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24080006_mdu_ctrl.sv
// Directed bench for ysyx_24080006_mdu_ctrl with a behavioural EX-stage adder on the side port.
module tb_ysyx_24080006_mdu_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic        mdu_enable;
    logic [31:0] out_data;
    logic [65:0] mdu2alu;
    logic [66:0] alu2mdu;
    logic [33:0] alu_res;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          en;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    always #5 clock = ~clock;

    assign alu_res = {1'b0, mdu2alu[65:33]} + {1'b0, mdu2alu[32:0]};
    assign alu2mdu = {alu_res, alu_res[32:1], |alu_res[32:1]};

    ysyx_24080006_mdu_ctrl #(.FAST_SPECIAL(1'b1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mdu_op     (mdu_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .mdu_enable (mdu_enable),
        .mdu2alu    (mdu2alu),
        .alu2mdu    (alu2mdu)
    );

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        mdu_op   = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        check("in_ready before accept", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int en);
        lat = 0;
        en  = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) begin
                @(posedge clock);
                #1;
            end
            if (mdu_enable) en++;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int en;
        int seen;

        vecs[0]  = '{3'b000, 32'd7,         32'd6,         32'd42,        37, 36};
        vecs[1]  = '{3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  37, 36};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  37, 36};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  37, 36};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  37, 36};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  37, 36};
        vecs[6]  = '{3'b101, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  37, 36};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         37, 36};
        vecs[8]  = '{3'b100, 32'd5,         32'd0,         32'hFFFFFFFF,  1,  0};
        vecs[9]  = '{3'b111, 32'd5,         32'd0,         32'd5,         1,  0};
        vecs[10] = '{3'b100, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1,  0};
        vecs[11] = '{3'b110, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1,  0};
        vecs[12] = '{3'b000, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  37, 36};
        vecs[13] = '{3'b001, 32'h80000000,  32'h80000000,  32'h40000000,  37, 36};
        vecs[14] = '{3'b001, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF,  37, 36};
        vecs[15] = '{3'b000, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFF1,  37, 36};
        vecs[16] = '{3'b100, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  37, 36};
        vecs[17] = '{3'b110, 32'd7,         32'hFFFFFFFE,  32'd1,         37, 36};
        vecs[18] = '{3'b110, 32'hFFFFFFF8,  32'd3,         32'hFFFFFFFE,  37, 36};
        vecs[19] = '{3'b110, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9,  1,  0};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst in_ready",   in_ready,   0);
        check("rst out_valid",  out_valid,  0);
        check("rst busy",       busy,       0);
        check("rst mdu_enable", mdu_enable, 0);
        check("rst mdu2alu",    mdu2alu,    0);
        check("rst out_data",   out_data,   0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post-rst in_ready", in_ready, 1);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, en);
            check($sformatf("v%0d data", i),       out_data, vecs[i].exp);
            check($sformatf("v%0d latency", i),    lat,      vecs[i].lat);
            check($sformatf("v%0d enable cyc", i), en,       vecs[i].en);
            @(posedge clock);
            #1;
            check($sformatf("v%0d idle after", i), busy, 0);
        end

        // Flush during ITER
        issue(3'b000, 32'd7, 32'd6);
        repeat (11) begin
            @(posedge clock);
            #1;
        end
        check("iter mdu_enable", mdu_enable, 1);
        check("iter busy",       busy,       1);
        check("iter in_ready",   in_ready,   0);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        check("flush in_ready",   in_ready,   1);
        check("flush mdu_enable", mdu_enable, 0);
        check("flush busy",       busy,       0);
        check("flush out_valid",  out_valid,  0);
        check("flush mdu2alu",    mdu2alu,    0);
        @(negedge clock);
        flush = 1'b0;
        seen = 0;
        repeat (45) begin
            @(posedge clock);
            #1;
            if (out_valid || busy) seen++;
        end
        check("flush no result", seen, 0);

        // Flush with in_valid in IDLE must not accept
        @(negedge clock);
        mdu_op   = 3'b000;
        op_a     = 32'd2;
        op_b     = 32'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("idle flush no accept", busy, 0);

        // Result held while consumer stalls
        out_ready = 1'b0;
        issue(3'b000, 32'd3, 32'd5);
        wait_done(lat, en);
        check("stall latency", lat, 37);
        check("stall data", out_data, 15);
        repeat (5) begin
            @(posedge clock);
            #1;
            check("stall out_valid", out_valid, 1);
            check("stall out_data",  out_data,  15);
            check("stall in_ready",  in_ready,  0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("handshake out_valid", out_valid, 0);
        check("handshake in_ready",  in_ready,  1);

        // Reset during FIX_LO clears out_data
        issue(3'b111, 32'd100, 32'd7);
        repeat (34) begin
            @(posedge clock);
            #1;
        end
        check("fixlo mdu_enable", mdu_enable, 1);
        check("fixlo out_data prev", out_data, 15);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("midrst in_ready",   in_ready,   0);
        check("midrst busy",       busy,       0);
        check("midrst mdu_enable", mdu_enable, 0);
        check("midrst out_valid",  out_valid,  0);
        check("midrst out_data",   out_data,   0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("midrst release in_ready", in_ready, 1);
        check("midrst release out_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
